frame_handoff_ctrl: RTL and testbench

Sequences delivery of game_state_pkg::game_state_t frames from the game logic to the VGA game decoder. It double-buffers the frames: one pending slot is written by the producer, and one display register drives the decoder's VGA_frame input. The display register is updated only at a vblank boundary, signalled by the decoder's VGA_new_frame_ready. This keeps the raster from ever showing a torn frame and decouples game tick rate from refresh rate.

---
 rtl/game_state_pkg.sv | 10 +
 rtl/frame_handoff_ctrl.sv | 122 ++++++++++++
 tb/tb_frame_handoff_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/game_state_pkg.sv
// Frame format exchanged between the game logic and the VGA game decoder.
// The screen tiles occupy the low bits so screen[0][0] is bit 0 of the frame.
package game_state_pkg;

  typedef struct packed {
    logic [15:0]     score;
    logic [3:0][7:0] screen;
  } game_state_t;

endpackage

// File: rtl/frame_handoff_ctrl.sv
// Double-buffered frame handoff: the producer fills a pending slot, and the
// display register takes that slot only on an eligible vblank edge.
module frame_handoff_ctrl
  import game_state_pkg::*;
#(
  parameter int unsigned OVERWRITE      = 1,
  parameter int unsigned SWAP_DIVIDE    = 1,
  parameter int unsigned DROP_CNT_BITS  = 8,
  parameter int unsigned FRAME_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  game_state_t               game_frame,
  input  logic                      game_frame_valid,
  output logic                      game_frame_ready,
  input  logic                      VGA_new_frame_ready,
  output game_state_t               VGA_frame,
  output logic                      frame_swapped,
  output logic [FRAME_CNT_BITS-1:0] frames_shown,
  output logic [DROP_CNT_BITS-1:0]  frames_dropped
);

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SWAP_DIVIDE - 32'd1);

  state_t      state_r;
  state_t      state_next_s;
  game_state_t pending_r;
  logic        vnr_r;
  logic [7:0]  div_cnt_r;
  logic        vblank_edge_s;
  logic        eligible_s;
  logic        accept_s;
  logic        swap_s;
  logic        drop_s;

  // Producer handshake: latest-wins mode never back-pressures.
  always_comb begin
    if (OVERWRITE != 32'd0) begin
      game_frame_ready = 1'b1;
    end else begin
      game_frame_ready = (state_r == EMPTY);
    end
  end

  // Event decode for the current cycle.
  always_comb begin
    vblank_edge_s = VGA_new_frame_ready & ~vnr_r;
    eligible_s    = vblank_edge_s & (div_cnt_r == DIV_LAST);
    accept_s      = game_frame_valid & game_frame_ready;
    swap_s        = eligible_s & (state_r == PENDING);
    drop_s        = accept_s & (state_r == PENDING) & ~swap_s;
  end

  // Next-state logic: an accept always leaves a frame pending.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_next_s = PENDING;
        end else begin
          state_next_s = EMPTY;
        end
      end
      PENDING: begin
        if (swap_s && !accept_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = PENDING;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: edge detect, divider, pending slot, display register, counters.
  // vnr_r resets high so a level already asserted out of reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vnr_r          <= 1'b1;
      div_cnt_r      <= 8'd0;
      pending_r      <= '0;
      VGA_frame      <= '0;
      frame_swapped  <= 1'b0;
      frames_shown   <= '0;
      frames_dropped <= '0;
    end else begin
      vnr_r         <= VGA_new_frame_ready;
      frame_swapped <= swap_s;
      if (eligible_s) begin
        div_cnt_r <= 8'd0;
      end else if (vblank_edge_s) begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end
      if (accept_s) begin
        pending_r <= game_frame;
      end
      if (swap_s) begin
        VGA_frame    <= pending_r;
        frames_shown <= frames_shown + FRAME_CNT_BITS'(1'b1);
      end
      if (drop_s && (frames_dropped != {DROP_CNT_BITS{1'b1}})) begin
        frames_dropped <= frames_dropped + DROP_CNT_BITS'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_frame_handoff_ctrl.sv
// Two controllers (latest-wins/every edge, and back-pressure/every third edge
// with narrow counters) share one stimulus and are checked against a frame model.
module tb_frame_handoff_ctrl;
  import game_state_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  game_state_t game_frame = '0;
  logic        game_frame_valid = 1'b0;
  logic        vnr = 1'b1;

  logic        ready_a, ready_b, sw_a, sw_b;
  game_state_t vga_a, vga_b;
  logic [15:0] shown_a;
  logic [7:0]  drop_a;
  logic [3:0]  shown_b;
  logic [2:0]  drop_b;

  frame_handoff_ctrl #(.OVERWRITE(1), .SWAP_DIVIDE(1), .DROP_CNT_BITS(8), .FRAME_CNT_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .game_frame(game_frame), .game_frame_valid(game_frame_valid),
    .game_frame_ready(ready_a), .VGA_new_frame_ready(vnr), .VGA_frame(vga_a),
    .frame_swapped(sw_a), .frames_shown(shown_a), .frames_dropped(drop_a));

  frame_handoff_ctrl #(.OVERWRITE(0), .SWAP_DIVIDE(3), .DROP_CNT_BITS(3), .FRAME_CNT_BITS(4)) dut_b (
    .clk(clk), .reset(reset), .game_frame(game_frame), .game_frame_valid(game_frame_valid),
    .game_frame_ready(ready_b), .VGA_new_frame_ready(vnr), .VGA_frame(vga_b),
    .frame_swapped(sw_b), .frames_shown(shown_b), .frames_dropped(drop_b));

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  // Per-instance configuration: index 0 is dut_a, index 1 is dut_b.
  int p_ow[2]   = '{1, 0};
  int p_div[2]  = '{1, 3};
  int p_dmax[2] = '{255, 7};
  int p_fmod[2] = '{65536, 16};

  // Model: a pending frame (or none), what is on screen, and plain counters.
  bit          m_pv[2];
  game_state_t m_pend[2];
  game_state_t m_disp[2];
  bit          m_pulse[2];
  int          m_shown[2];
  int          m_drop[2];
  int          m_edges[2];
  bit          m_vprev = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit e, acc, elig, sw;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_pv[i] = 1'b0; m_pend[i] = '0; m_disp[i] = '0; m_pulse[i] = 1'b0;
        m_shown[i] = 0; m_drop[i] = 0; m_edges[i] = 0;
      end
      m_vprev = 1'b1;
    end else begin
      e = vnr && !m_vprev;
      m_vprev = vnr;
      for (int i = 0; i < 2; i++) begin
        acc  = game_frame_valid && (p_ow[i] == 1 || !m_pv[i]);
        elig = 1'b0;
        if (e) begin
          m_edges[i]++;
          elig = (m_edges[i] % p_div[i]) == 0;
        end
        sw = elig && m_pv[i];
        m_pulse[i] = sw;
        if (sw) begin
          m_disp[i]  = m_pend[i];
          m_shown[i] = (m_shown[i] + 1) % p_fmod[i];
        end
        if (acc) begin
          if (m_pv[i] && !sw && m_drop[i] < p_dmax[i]) m_drop[i]++;
          m_pend[i] = game_frame;
          m_pv[i]   = 1'b1;
        end else if (sw) begin
          m_pv[i] = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of both controllers against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ready_a", 64'(ready_a), 64'(p_ow[0] == 1 || !m_pv[0]));
      chk("vga_a", 64'(vga_a), 64'(m_disp[0]));
      chk("swapped_a", 64'(sw_a), 64'(m_pulse[0]));
      chk("shown_a", 64'(shown_a), 64'(m_shown[0]));
      chk("dropped_a", 64'(drop_a), 64'(m_drop[0]));
      chk("ready_b", 64'(ready_b), 64'(p_ow[1] == 1 || !m_pv[1]));
      chk("vga_b", 64'(vga_b), 64'(m_disp[1]));
      chk("swapped_b", 64'(sw_b), 64'(m_pulse[1]));
      chk("shown_b", 64'(shown_b), 64'(m_shown[1]));
      chk("dropped_b", 64'(drop_b), 64'(m_drop[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic game_state_t rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  game_state_t f1, fr0, fr1, fr2, g1, g2;
  int vcnt = 0;

  initial begin
    repeat (3) tick();
    reset  = 1'b0;
    cmp_on = 1'b1;
    chk("rst_vga", 64'(vga_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_shown", 64'(shown_a), 64'd0);
    chk("rst_dropped", 64'(drop_a), 64'd0);
    repeat (10) tick();
    chk("high_level_no_swap", 64'(shown_a), 64'd0);

    // Single frame, then one vblank edge held high for a long time.
    vnr = 1'b0; tick();
    f1 = '0; f1.screen[0][0] = 1'b1;
    game_frame = f1; game_frame_valid = 1'b1; tick();
    game_frame_valid = 1'b0; tick();
    vnr = 1'b1; tick();
    chk("f1_vga", 64'(vga_a), 64'h1);
    chk("f1_pulse", 64'(sw_a), 64'd1);
    chk("f1_shown", 64'(shown_a), 64'd1);
    tick();
    chk("f1_pulse_end", 64'(sw_a), 64'd0);
    repeat (50) tick();
    chk("f1_single_swap", 64'(shown_a), 64'd1);

    // Three frames before one edge: latest wins, two dropped.
    vnr = 1'b0; tick();
    fr0 = rand_frame(); fr1 = rand_frame(); fr2 = rand_frame();
    game_frame = fr0; game_frame_valid = 1'b1; tick();
    game_frame = fr1; tick();
    game_frame = fr2; tick();
    game_frame_valid = 1'b0; vnr = 1'b1; tick();
    chk("ow_vga", 64'(vga_a), 64'(fr2));
    chk("ow_dropped", 64'(drop_a), 64'd2);

    // Accept on the swap cycle: old frame shown, new one waits.
    vnr = 1'b0; tick();
    g1 = rand_frame(); g2 = rand_frame();
    game_frame = g1; game_frame_valid = 1'b1; tick();
    game_frame = g2; vnr = 1'b1; tick();
    game_frame_valid = 1'b0;
    chk("same_cycle_vga", 64'(vga_a), 64'(g1));
    chk("same_cycle_dropped", 64'(drop_a), 64'd2);
    vnr = 1'b0; tick();
    vnr = 1'b1; tick();
    chk("same_cycle_next", 64'(vga_a), 64'(g2));

    // Sustained overwrites with no vblank saturate the drop counter.
    vnr = 1'b0; game_frame_valid = 1'b1;
    repeat (300) begin
      game_frame = rand_frame(); tick();
    end
    game_frame_valid = 1'b0;
    chk("drop_saturate", 64'(drop_a), 64'd255);

    // Random traffic against a random vblank waveform, with rare resets.
    for (int c = 0; c < 5000; c++) begin
      if (vcnt == 0) begin
        vnr  = ~vnr;
        vcnt = vnr ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 25));
      end else begin
        vcnt--;
      end
      game_frame_valid = ($urandom() % 4) == 0;
      game_frame       = rand_frame();
      reset            = ($urandom() % 1500) == 0;
      tick();
    end
    reset = 1'b0; game_frame_valid = 1'b0;

    // Reset while a frame is pending discards it.
    vnr = 1'b0; tick();
    game_frame = rand_frame(); game_frame_valid = 1'b1; tick();
    game_frame_valid = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    chk("rst_mid_vga", 64'(vga_a), 64'd0);
    chk("rst_mid_shown", 64'(shown_a), 64'd0);
    tick();
    vnr = 1'b1; tick();
    chk("rst_mid_no_swap", 64'(shown_a), 64'd0);
    chk("rst_mid_still_blank", 64'(vga_a), 64'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
